// File: rtl/symbol_writer_pkg.sv
// symbol_writer_pkg: shared widths, FSM state type and bit-reverse helper for the glyph loader.
package symbol_writer_pkg;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_ROWS = 16;
  localparam int CODE_W = 8;
  localparam int GLYPH_ADDR_W = 12;
  typedef enum logic [1:0] {IDLE, ROWS, DONE} state_e;
  function automatic logic [GLYPH_W-1:0] bitrev8(input logic [GLYPH_W-1:0] d);
    for (int i = 0; i < GLYPH_W; i++) bitrev8[GLYPH_W-1-i] = d[i];
  endfunction
endpackage

// File: rtl/symbol_writer_if.sv
// symbol_writer_if: byte-stream input, glyph RAM write port and status flags of the glyph loader.
interface symbol_writer_if;
  import symbol_writer_pkg::*;
  logic in_valid;
  logic [GLYPH_W-1:0] in_data;
  logic in_ready;
  logic wr_en;
  logic [GLYPH_ADDR_W-1:0] wr_addr;
  logic [GLYPH_W-1:0] wr_data;
  logic busy;
  logic done;
  logic err;
  modport master (input in_valid, in_data, output in_ready, wr_en, wr_addr, wr_data, busy, done, err);
  modport slave (output in_valid, in_data, input in_ready, wr_en, wr_addr, wr_data, busy, done, err);
endinterface

// File: rtl/symbol_writer_timeout.sv
// symbol_writer_timeout: idle-cycle counter; expired_o pulses on the TIMEOUT-th consecutive enabled, uncleared cycle.
module symbol_writer_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  assign expired_o = en_i && !clr_i && cnt_q == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/symbol_writer.sv
// symbol_writer: loads 8x16 glyphs from a valid/ready byte stream into the glyph RAM write port.
// Define SYMBOL_WRITER_BITREV_EN to store row bytes bit-reversed for read sides indexing [7-pix_x].
module symbol_writer import symbol_writer_pkg::*; #(
  parameter int ROWS = GLYPH_ROWS,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  symbol_writer_if.master bus
);
  localparam int ROW_W = $clog2(ROWS);
  state_e state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic ready_q, wr_en_q, wr_en_d, err_q;
  logic [GLYPH_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [GLYPH_W-1:0] wr_data_q, wr_data_d, row_bits;
  logic accept, in_rows, expired;
  assign accept = bus.in_valid && ready_q;
  assign in_rows = state_q == symbol_writer_pkg::ROWS;
`ifdef SYMBOL_WRITER_BITREV_EN
  assign row_bits = bitrev8(bus.in_data);
`else
  assign row_bits = bus.in_data;
`endif
  symbol_writer_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk,
    .rst,
    .clr_i(accept || !in_rows),
    .en_i(in_rows),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    row_d = row_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (accept) begin
        code_d = bus.in_data;
        row_d = '0;
        state_d = symbol_writer_pkg::ROWS;
      end
      symbol_writer_pkg::ROWS: if (accept) begin
        wr_en_d = 1'b1;
        wr_addr_d = GLYPH_ADDR_W'({code_q, row_q});
        wr_data_d = row_bits;
        row_d = row_q + 1'b1;
        state_d = row_q == ROW_W'(ROWS - 1) ? DONE : symbol_writer_pkg::ROWS;
      end else if (expired) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // in_ready is registered from the next state so it never depends on in_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q <= '0;
      row_q <= '0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      row_q <= row_d;
      ready_q <= state_d != DONE;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q <= expired;
    end
  end
  assign bus.in_ready = ready_q;
  assign bus.wr_en = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.err = err_q;
endmodule

// File: tb/tb_symbol_writer.sv
// tb_symbol_writer: scoreboard bench for the glyph loader; expected RAM writes are queued as row bytes are driven.
`timescale 1ns/1ps
module tb_symbol_writer;
  localparam int TO = 1024;
  typedef struct { logic [11:0] addr; logic [7:0] data; logic [7:0] din; } exp_t;
  typedef struct { logic [7:0] din; logic [11:0] addr; logic [7:0] data; } vec_t;
`ifdef SYMBOL_WRITER_BITREV_EN
  localparam logic [7:0] ONE_EXP = 8'h80;
`else
  localparam logic [7:0] ONE_EXP = 8'h01;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_fail = 0, cyc = 0, err_cnt = 0, last_acc = 0;
  exp_t q[$];
  exp_t mon_e;
  symbol_writer_if sif();
  symbol_writer #(.ROWS(16), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(sif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model(input logic [7:0] d);
`ifdef SYMBOL_WRITER_BITREV_EN
    return {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (sif.err) err_cnt++;
    if (sif.wr_en) begin
      if (q.size() == 0) check("unexpected_write", 32'(sif.wr_addr), 32'hFFFF_FFFF);
      else begin
        mon_e = q.pop_front();
        check("wr_addr", 32'(sif.wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(sif.wr_data), 32'(mon_e.data));
        check("done_on_last_row", 32'(sif.done), 32'(mon_e.addr[3:0] == 4'hF));
        if (mon_e.din == 8'h01) check("bitrev_01", 32'(sif.wr_data), 32'(ONE_EXP));
      end
    end else if (sif.done) check("done_without_write", 32'(sif.done), 0);
  end

  task automatic expect_wr(input logic [11:0] addr, input logic [7:0] din);
    exp_t e;
    e.addr = addr;
    e.data = model(din);
    e.din = din;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    sif.in_valid = 1'b1;
    sif.in_data = d;
    @(negedge clk);
    while (!sif.in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    check("in_ready_for_byte", 32'(sif.in_ready), 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    sif.in_valid = 1'b0;
  endtask

  task automatic gap(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("busy_in_gap", 32'(sif.busy), 1);
      check("no_err_in_gap", 32'(sif.err), 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rows_only(input logic [7:0] code, input logic [15:0][7:0] rows, input int max_gap, input int long_at);
    for (int r = 0; r < 16; r++) begin
      expect_wr({code, 4'(r)}, rows[r]);
      send(rows[r]);
      if (r < 15) gap(r == long_at ? TO - 1 : (max_gap > 0 ? int'($urandom_range(max_gap, 0)) : 0));
    end
  endtask

  task automatic frame(input logic [7:0] code, input logic [15:0][7:0] rows, input int max_gap, input int long_at);
    send(code);
    rows_only(code, rows, max_gap, long_at);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[16];
    logic [7:0] glyph_a[16];
    logic [15:0][7:0] rnd, ones, misc;
    int t0, w;
    glyph_a = '{8'h00, 8'h18, 8'h3C, 8'h66, 8'hC3, 8'hC3, 8'hFF, 8'hC3,
                8'hC3, 8'hC3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
    for (int i = 0; i < 16; i++) vt[i] = '{din: glyph_a[i], addr: 12'h410 + 12'(i), data: model(glyph_a[i])};
    for (int i = 0; i < 16; i++) rnd[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) ones[i] = 8'h01;
    for (int i = 0; i < 16; i++) misc[i] = 8'(8'h01 + 8'(i * 17));
    sif.in_valid = 1'b0;
    sif.in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(sif.in_ready), 0);
    check("rst_wr_en", 32'(sif.wr_en), 0);
    check("rst_wr_addr", 32'(sif.wr_addr), 0);
    check("rst_wr_data", 32'(sif.wr_data), 0);
    check("rst_busy", 32'(sif.busy), 0);
    check("rst_done", 32'(sif.done), 0);
    check("rst_err", 32'(sif.err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_rst", 32'(sif.in_ready), 1);
    @(posedge clk);
    #1;

    // full-rate 0x41 from the table, with code 0x42 held across DONE
    send(8'h41);
    t0 = last_acc;
    for (int i = 0; i < 16; i++) begin
      expect_wr(vt[i].addr, vt[i].din);
      check("table_model", 32'(vt[i].data), 32'(model(vt[i].din)));
      send(vt[i].din);
    end
    sif.in_valid = 1'b1;
    sif.in_data = 8'h42;
    @(negedge clk);
    check("done_in_ready_low", 32'(sif.in_ready), 0);
    check("done_pulse", 32'(sif.done), 1);
    check("done_busy", 32'(sif.busy), 1);
    send(8'h42);
    check("frame_period", 32'(last_acc - t0), 18);
    rows_only(8'h42, ones, 0, -1);

    // random gaps on 0x7E, one gap of exactly TIMEOUT-1 idle cycles
    frame(8'h7E, rnd, 20, 7);
    repeat (2) @(posedge clk);
    #1;
    check("gaps_no_err", 32'(err_cnt), 0);
    check("gaps_queue_empty", 32'(q.size()), 0);

    // stall after 5 rows of 0x30
    send(8'h30);
    for (int r = 0; r < 5; r++) begin
      expect_wr({8'h30, 4'(r)}, misc[r]);
      send(misc[r]);
    end
    t0 = last_acc;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!sif.err && w < 3 * TO);
    check("err_seen", 32'(sif.err), 1);
    check("err_latency", 32'(cyc - t0), TO);
    check("err_in_ready", 32'(sif.in_ready), 1);
    check("err_busy", 32'(sif.busy), 0);
    @(negedge clk);
    check("err_one_cycle", 32'(sif.err), 0);
    @(posedge clk);
    #1;
    check("err_count", 32'(err_cnt), 1);
    check("stall_queue_empty", 32'(q.size()), 0);
    frame(8'h31, misc, 3, -1);

    // reset after the 8th row of 0x55
    send(8'h55);
    for (int r = 0; r < 8; r++) begin
      expect_wr({8'h55, 4'(r)}, rnd[r]);
      send(rnd[r]);
    end
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_wr_en", 32'(sif.wr_en), 0);
      check("mid_rst_addr", 32'(sif.wr_addr), 0);
      check("mid_rst_data", 32'(sif.wr_data), 0);
      check("mid_rst_busy", 32'(sif.busy), 0);
      check("mid_rst_done", 32'(sif.done), 0);
      check("mid_rst_in_ready", 32'(sif.in_ready), 0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(sif.in_ready), 1);
    check("post_rst_queue_empty", 32'(q.size()), 0);
    @(posedge clk);
    #1;
    frame(8'h56, misc, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(q.size()), 0);
    check("final_err_count", 32'(err_cnt), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
